// File: rtl/scan_pkg.sv
// Shared constants for the line scan sequencer: line count, select width, FSM encodings.
package scan_pkg;

  localparam int LINES   = 8;
  localparam int SEL_W   = 3;
  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 2'd1;
  localparam logic [STATE_W-1:0] ST_BLANK  = 2'd2;

endpackage

// File: rtl/mask_next_line.sv
// Picks the next enabled line strictly above cur, falling back to the lowest enabled line.
// Purely combinational; cur=7 always yields the lowest set bit with wrap=1.
module mask_next_line
  import scan_pkg::*;
(
  input  logic [LINES-1:0] i_mask,
  input  logic [SEL_W-1:0] i_cur,
  output logic [SEL_W-1:0] o_next,
  output logic             o_wrap
);

  logic             w_above_vld;
  logic [SEL_W-1:0] w_above;
  logic [SEL_W-1:0] w_low;

  // Descending scan so the last hit in each category is the lowest index.
  always_comb begin
    w_above_vld = 1'b0;
    w_above     = '0;
    w_low       = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        w_low = SEL_W'(i);
        if (i > int'(i_cur)) begin
          w_above_vld = 1'b1;
          w_above     = SEL_W'(i);
        end
      end
    end
  end

  assign o_next = w_above_vld ? w_above : w_low;
  assign o_wrap = ~w_above_vld;

endmodule

// File: rtl/line_scan_sequencer.sv
// Drives sel/en of a 3:8 decoder through the enabled lines, dwell+1 cycles each plus one blank cycle.
// First line one cycle after start; all outputs registered; stop aborts to IDLE the next cycle.
module line_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_mode,
  input  logic [LINES-1:0]   i_mask,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_en,
  output logic               o_busy,
  output logic               o_line_tick,
  output logic               o_done
);

  logic [STATE_W-1:0] r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic [LINES-1:0]   r_mask_q;
  logic [DWELL_W-1:0] r_dwell_q;
  logic               r_mode_q;
  logic [SEL_W-1:0]   r_sel;
  logic               r_en;
  logic               r_busy;
  logic               r_line_tick;
  logic               r_done;

  logic               w_idle;
  logic [LINES-1:0]   w_nl_mask;
  logic [SEL_W-1:0]   w_nl_cur;
  logic [SEL_W-1:0]   w_nl_next;
  logic               w_nl_wrap;
  logic               w_last_cycle;
  logic [DWELL_W-1:0] w_cnt_inc;

  // One search unit: in IDLE it finds the first line of the live mask, otherwise the successor of sel.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_nl_mask = w_idle ? i_mask : r_mask_q;
  assign w_nl_cur  = w_idle ? SEL_W'(LINES - 1) : r_sel;

  mask_next_line u_next (
    .i_mask (w_nl_mask),
    .i_cur  (w_nl_cur),
    .o_next (w_nl_next),
    .o_wrap (w_nl_wrap)
  );

  assign w_last_cycle = (r_cnt == r_dwell_q);
  assign w_cnt_inc    = r_cnt + DWELL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mask_q    <= '0;
      r_dwell_q   <= '0;
      r_mode_q    <= 1'b0;
      r_sel       <= '0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_line_tick <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_line_tick <= 1'b0;
      r_done      <= 1'b0;
      if (i_stop) begin
        r_state <= ST_IDLE;
        r_en    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              if (i_mask != '0) begin
                r_mask_q    <= i_mask;
                r_dwell_q   <= i_dwell;
                r_mode_q    <= i_mode;
                r_sel       <= w_nl_next;
                r_cnt       <= '0;
                r_state     <= ST_ACTIVE;
                r_en        <= 1'b1;
                r_busy      <= 1'b1;
                r_line_tick <= (i_dwell == '0);
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          ST_ACTIVE: begin
            if (w_last_cycle) begin
              r_en <= 1'b0;
              // Single pass ends on the highest line; sel keeps pointing at it.
              if (w_nl_wrap && r_mode_q) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_sel   <= w_nl_next;
                r_state <= ST_BLANK;
              end
            end else begin
              r_cnt       <= w_cnt_inc;
              r_line_tick <= (w_cnt_inc == r_dwell_q);
            end
          end
          ST_BLANK: begin
            r_cnt       <= '0;
            r_state     <= ST_ACTIVE;
            r_en        <= 1'b1;
            r_line_tick <= (r_dwell_q == '0);
          end
          default: begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_sel       = r_sel;
  assign o_en        = r_en;
  assign o_busy      = r_busy;
  assign o_line_tick = r_line_tick;
  assign o_done      = r_done;

endmodule
